iir_inverse_fir: RTL and testbench

- Streaming all-zero (FIR) inverse of the team's 4th-order all-pole IIR section.
- Given filtered samples y[n], it recovers the excitation: e[n] = y[n] - sum_{k=1..4} a_k * y[n-k].
- Sits downstream of the IIR block in the loopback/verification path; with matching coefficients, the chain IIR -> iir_inverse_fir returns the original input to within rounding.
- 8-bit signed samples in and out, valid/ready on both sides, 2-stage pipeline.

---
 rtl/iir_pkg.sv | 21 ++
 rtl/sample_delay_line.sv | 48 ++++
 rtl/iir_inverse_fir.sv | 130 +++++++++++++
 tb/tb_iir_inverse_fir.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Purpose: shared constants for the 4th-order all-pole IIR section and its FIR inverse.
// Latency: n/a (constants only).
// Backpressure: n/a.
// The default coefficients live here so both ends of the loopback match.
package iir_pkg;

    localparam int DATA_W = 8;                 // sample width, signed
    localparam int COEF_W = 8;                 // coefficient width, signed Q1.(COEF_W-2)
    localparam int FRAC   = 6;                 // coefficient fractional bits
    localparam int ACC_W  = 19;                // accumulator width, no internal overflow

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // a_1..a_4 in Q1.6
    localparam int COEF_1 = 32;                // 0.5
    localparam int COEF_2 = -16;               // -0.25
    localparam int COEF_3 = 0;
    localparam int COEF_4 = 0;

endpackage

// File: rtl/sample_delay_line.sv
// Purpose: 4-deep sample history (h1 newest) with shift enable and synchronous clear.
// Latency: outputs reflect the shift/clear one clock after it is requested.
// Backpressure: none; holds whenever neither shift nor clear is asserted.
// Ports: clk, rst_n (async active-low), i_shift, i_clr, i_din, o_h1..o_h4.
// Clear and shift together load i_din into h1 and zero h2..h4.
module sample_delay_line
    import iir_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_shift,
    input  logic         i_clr,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_h1,
    output logic [W-1:0] o_h2,
    output logic [W-1:0] o_h3,
    output logic [W-1:0] o_h4
);

    logic [W-1:0] r_h1, r_h2, r_h3, r_h4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1 <= '0;
            r_h2 <= '0;
            r_h3 <= '0;
            r_h4 <= '0;
        end else if (i_clr) begin
            r_h1 <= i_shift ? i_din : '0;
            r_h2 <= '0;
            r_h3 <= '0;
            r_h4 <= '0;
        end else if (i_shift) begin
            r_h1 <= i_din;
            r_h2 <= r_h1;
            r_h3 <= r_h2;
            r_h4 <= r_h3;
        end
    end

    assign o_h1 = r_h1;
    assign o_h2 = r_h2;
    assign o_h3 = r_h3;
    assign o_h4 = r_h4;

endmodule

// File: rtl/iir_inverse_fir.sv
// Purpose: FIR inverse of the all-pole IIR, e[n] = y[n] - sum a_k*y[n-k], rounded and saturated.
// Latency: 2 clocks (products, then accumulate/round/saturate); 1 sample/clock when not stalled.
// Backpressure: a held output (out_valid & !out_ready) freezes pipeline and history; in_ready drops.
// Ports: clk, rst (async active-low), hist_clr, din/in_valid/in_ready, dout/out_valid/out_ready.
module iir_inverse_fir #(
    parameter int DATA_W = iir_pkg::DATA_W,
    parameter int COEF_W = iir_pkg::COEF_W,
    parameter int FRAC   = iir_pkg::FRAC,
    parameter int COEF_1 = iir_pkg::COEF_1,
    parameter int COEF_2 = iir_pkg::COEF_2,
    parameter int COEF_3 = iir_pkg::COEF_3,
    parameter int COEF_4 = iir_pkg::COEF_4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hist_clr,
    input  logic [DATA_W-1:0] din,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PROD_W = COEF_W + DATA_W;
    localparam int ACC_W  = iir_pkg::ACC_W;
    localparam int R_W    = ACC_W - FRAC;

    localparam logic signed [COEF_W-1:0] C1 = COEF_W'(COEF_1);
    localparam logic signed [COEF_W-1:0] C2 = COEF_W'(COEF_2);
    localparam logic signed [COEF_W-1:0] C3 = COEF_W'(COEF_3);
    localparam logic signed [COEF_W-1:0] C4 = COEF_W'(COEF_4);

    localparam logic signed [R_W-1:0] R_MAX = R_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [R_W-1:0] R_MIN = R_W'(-(2 ** (DATA_W - 1)));

    logic                     w_en;
    logic                     w_accept;
    logic                     w_clr;
    logic signed [DATA_W-1:0] w_din;
    logic        [DATA_W-1:0] w_h1_u, w_h2_u, w_h3_u, w_h4_u;
    logic signed [DATA_W-1:0] w_h1, w_h2, w_h3, w_h4;
    logic signed [PROD_W-1:0] w_p0, w_p1, w_p2, w_p3, w_p4;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [R_W-1:0]    w_r;
    logic signed [DATA_W-1:0] w_sat;

    logic signed [PROD_W-1:0] r_p0, r_p1, r_p2, r_p3, r_p4;
    logic                     r_s1_vld;
    logic        [DATA_W-1:0] r_dout;
    logic                     r_out_valid;

    // The whole pipeline advances together; an unconsumed output holds everything.
    assign w_en     = !r_out_valid | out_ready;
    assign in_ready = w_en & rst;
    assign w_accept = in_valid & w_en;
    assign w_clr    = hist_clr & w_en;

    assign w_din = din;

    sample_delay_line #(
        .W (DATA_W)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst),
        .i_shift (w_accept),
        .i_clr   (w_clr),
        .i_din   (din),
        .o_h1    (w_h1_u),
        .o_h2    (w_h2_u),
        .o_h3    (w_h3_u),
        .o_h4    (w_h4_u)
    );

    assign w_h1 = w_h1_u;
    assign w_h2 = w_h2_u;
    assign w_h3 = w_h3_u;
    assign w_h4 = w_h4_u;

    // Products use history as it stands before this cycle's shift.
    assign w_p0 = PROD_W'(w_din) <<< FRAC;
    assign w_p1 = PROD_W'(C1) * PROD_W'(w_h1);
    assign w_p2 = PROD_W'(C2) * PROD_W'(w_h2);
    assign w_p3 = PROD_W'(C3) * PROD_W'(w_h3);
    assign w_p4 = PROD_W'(C4) * PROD_W'(w_h4);

    assign w_acc = ACC_W'(r_p0) - ACC_W'(r_p1) - ACC_W'(r_p2)
                 - ACC_W'(r_p3) - ACC_W'(r_p4);

    // Round half up: add half an LSB, then floor via arithmetic shift.
    assign w_rnd = w_acc + ACC_W'(2 ** (FRAC - 1));
    assign w_r   = R_W'(w_rnd >>> FRAC);

    always_comb begin
        w_sat = DATA_W'(w_r);
        if (w_r > R_MAX) begin
            w_sat = DATA_W'(R_MAX);
        end else if (w_r < R_MIN) begin
            w_sat = DATA_W'(R_MIN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_p3        <= '0;
            r_p4        <= '0;
            r_s1_vld    <= 1'b0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_p0        <= w_p0;
            // A clear alongside an accept means this sample sees empty history.
            r_p1        <= hist_clr ? '0 : w_p1;
            r_p2        <= hist_clr ? '0 : w_p2;
            r_p3        <= hist_clr ? '0 : w_p3;
            r_p4        <= hist_clr ? '0 : w_p4;
            r_s1_vld    <= w_accept;
            r_dout      <= w_sat;
            r_out_valid <= r_s1_vld;
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_iir_inverse_fir.sv
module tb_iir_inverse_fir;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hist_clr = 1'b0;
    logic [7:0] din = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready = 1'b1;

    iir_inverse_fir dut (
        .clk       (clk),
        .rst       (rst),
        .hist_clr  (hist_clr),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int m_h[4];
    bit use_forced = 1'b0;
    int forced_exp = 0;

    typedef struct {
        int d;
        bit clr;
        int exp;
    } vec_t;
    vec_t tbl[13];

    // Reference: a1=0.5, a2=-0.25, a3=a4=0 in Q1.6, round half up, saturate to 8 bits.
    function automatic int ref_out(int d, int h1, int h2, int h3, int h4);
        int acc;
        int r;
        acc = d * 64 - 32 * h1 - (-16) * h2 - 0 * h3 - 0 * h4;
        r = (acc + 32) >>> 6;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_model();
        for (int k = 0; k < 4; k++) m_h[k] = 0;
    endtask

    // One clock: sample handshakes mid-cycle, update scoreboard, advance past the edge.
    task automatic tick();
        int d;
        int e;
        #1;
        chk("in_ready_vs_en", int'(in_ready), int'(!out_valid || out_ready));
        if (in_ready && hist_clr) clr_model();
        if (in_valid && in_ready) begin
            d = int'($signed(din));
            e = use_forced ? forced_exp : ref_out(d, m_h[0], m_h[1], m_h[2], m_h[3]);
            exp_q.push_back(e);
            m_h[3] = m_h[2];
            m_h[2] = m_h[1];
            m_h[1] = m_h[0];
            m_h[0] = d;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'($signed(dout)), 9999);
            end else begin
                chk("scoreboard_dout", int'($signed(dout)), exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        hist_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic send(input int d, input bit clr, input int exp);
        din = d[7:0];
        hist_clr = clr;
        in_valid = 1'b1;
        forced_exp = exp;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int frozen;

        tbl = '{
            '{64, 1'b1, 64}, '{0, 1'b0, -32}, '{0, 1'b0, 16}, '{0, 1'b0, 0}, '{0, 1'b0, 0},
            '{127, 1'b1, 127}, '{127, 1'b0, 64}, '{127, 1'b0, 95}, '{127, 1'b0, 95},
            '{-128, 1'b1, -128}, '{127, 1'b0, 127},
            '{127, 1'b1, 127}, '{-128, 1'b0, -128}
        };
        clr_model();

        // Reset state
        #12;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_dout", int'(dout), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("in_ready_after_release", int'(in_ready), 1);

        // Table-driven: impulse, step with rounding, saturation both ways
        use_forced = 1'b1;
        for (int i = 0; i < 13; i++) send(tbl[i].d, tbl[i].clr, tbl[i].exp);
        use_forced = 1'b0;
        drain();

        // Latency: output valid exactly two cycles after accept
        use_forced = 1'b1;
        send(64, 1'b1, 64);
        use_forced = 1'b0;
        in_valid = 1'b0;
        hist_clr = 1'b0;
        chk("latency_cycle1_valid", int'(out_valid), 0);
        tick();
        chk("latency_cycle2_valid", int'(out_valid), 1);
        chk("latency_cycle2_dout", int'($signed(dout)), 64);
        drain();

        // Backpressure: stall 5 cycles after first output
        use_forced = 1'b1;
        send(1, 1'b1, 1);
        send(2, 1'b0, 2);
        chk("bp_first_valid", int'(out_valid), 1);
        out_ready = 1'b0;
        din = 8'd3;
        in_valid = 1'b1;
        frozen = int'($signed(dout));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_dout_frozen", int'($signed(dout)), frozen);
            chk("bp_valid_held", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(3, 1'b0, 2);
        send(4, 1'b0, 3);
        use_forced = 1'b0;
        drain();

        // Bubbles: sparse step must match the dense step response
        use_forced = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) begin
                forced_exp = (i == 0) ? 127 : (i == 2) ? 64 : 95;
                din = 8'd127;
                hist_clr = (i == 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                hist_clr = 1'b0;
            end
            tick();
        end
        use_forced = 1'b0;
        drain();

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            din = 8'($urandom_range(0, 255));
            hist_clr = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // hist_clr pulse over non-zero history gives the clean impulse response
        use_forced = 1'b1;
        send(64, 1'b1, 64);
        send(0, 1'b0, -32);
        send(0, 1'b0, 16);
        send(0, 1'b0, 0);
        send(0, 1'b0, 0);
        use_forced = 1'b0;
        drain();

        // Async reset mid-stream with two samples in flight
        send(100, 1'b0, 0);
        send(90, 1'b0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_dout", int'(dout), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        clr_model();
        @(posedge clk);
        #1;
        chk("async_rst_hold_valid", int'(out_valid), 0);
        rst = 1'b1;
        use_forced = 1'b1;
        send(64, 1'b0, 64);
        send(0, 1'b0, -32);
        send(0, 1'b0, 16);
        use_forced = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
